// File: rtl/diff_codec.sv
// diff_codec -- M-ary differential encoder/decoder for the DQPSK datapath.
//
// One block covers TX (encode) and RX (decode), selected by `mode`. All
// arithmetic is modulo 2^SYM_W. The phase reference is forced to zero at
// every frame start (every FRAME_LEN symbols), on `sync_clr`, and whenever
// `mode` changes. A single output register with valid/ready handshaking
// gives 1-cycle latency and 1 symbol/cycle throughput.
//
// Optional feature: define DIFF_GRAY_EN to Gray-map the symbol side
// (Gray->binary on encode input, binary->Gray on decode output).
//
// Ports:
//   clk, rstn        symbol clock, async active-low reset
//   mode             0 = encode, 1 = decode (quasi-static)
//   sync_clr         1-cycle synchronous frame restart
//   in_valid/in_ready/in_data     upstream handshake + symbol/code
//   out_valid/out_ready/out_data  downstream handshake + code/symbol
//   out_sof          out_data is the first symbol of a frame
module diff_codec #(
  parameter int SYM_W     = 2,
  parameter int FRAME_LEN = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             mode,
  input  logic             sync_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYM_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] out_data,
  output logic             out_sof
);

  localparam int              CNT_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_LEN - 1);

  logic [SYM_W-1:0] ref_q, ref_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q;
  logic             out_valid_q, out_valid_d;
  logic [SYM_W-1:0] out_data_q, out_data_d;
  logic             out_sof_q, out_sof_d;

  logic             xfer_in, restart, first;
  logic [SYM_W-1:0] ref_eff, sym_bin, enc_code, dec_bin, dec_sym;
  logic [CNT_W-1:0] cnt_base;

  assign in_ready = !out_valid_q || out_ready;
  assign xfer_in  = in_valid && in_ready;

  // A restart request or a direction change both re-anchor the reference.
  assign restart  = sync_clr || (mode != mode_q);
  assign first    = (cnt_q == '0) || restart;
  assign ref_eff  = first ? '0 : ref_q;
  assign cnt_base = first ? '0 : cnt_q;

`ifdef DIFF_GRAY_EN
  function automatic logic [SYM_W-1:0] gray2bin(input logic [SYM_W-1:0] g);
    logic [SYM_W-1:0] b;
    b[SYM_W-1] = g[SYM_W-1];
    for (int i = SYM_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign sym_bin = gray2bin(in_data);
  assign dec_sym = dec_bin ^ (dec_bin >> 1);
`else
  assign sym_bin = in_data;
  assign dec_sym = dec_bin;
`endif

  assign enc_code = ref_eff + sym_bin;
  assign dec_bin  = in_data - ref_eff;

  always_comb begin
    ref_d       = ref_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_sof_d   = out_sof_q;
    out_valid_d = out_valid_q;
    if (xfer_in) begin
      // Encoder accumulates its own output; decoder remembers the raw code.
      ref_d       = mode ? in_data : enc_code;
      out_data_d  = mode ? dec_sym : enc_code;
      out_sof_d   = first;
      cnt_d       = (cnt_base == CNT_MAX) ? '0 : cnt_base + 1'b1;
      out_valid_d = 1'b1;
    end else begin
      if (restart) begin
        cnt_d = '0;
        ref_d = '0;
      end
      if (out_ready) out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ref_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
    end else begin
      ref_q       <= ref_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sof   = out_sof_q;

endmodule

// File: tb/tb_diff_codec.sv
// Directed bench for diff_codec, SYM_W=2. Two instances share all inputs:
// u_a uses FRAME_LEN=64, u_b uses FRAME_LEN=4 (frame-wrap case). Expected
// values are hand-computed in binary; gmap() applies the Gray relabelling of
// the symbol side when DIFF_GRAY_EN is defined so the same table serves both
// builds.
module tb_diff_codec;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       mode = 1'b0, sync_clr = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [1:0] in_data = '0;
  logic       a_ir, a_ov, a_sof, b_ir, b_ov, b_sof;
  logic [1:0] a_od, b_od;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  diff_codec #(.SYM_W(2), .FRAME_LEN(64)) u_a (
    .clk(clk), .rstn(rstn), .mode(mode), .sync_clr(sync_clr),
    .in_valid(in_valid), .in_ready(a_ir), .in_data(in_data),
    .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od), .out_sof(a_sof));

  diff_codec #(.SYM_W(2), .FRAME_LEN(4)) u_b (
    .clk(clk), .rstn(rstn), .mode(mode), .sync_clr(sync_clr),
    .in_valid(in_valid), .in_ready(b_ir), .in_data(in_data),
    .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od), .out_sof(b_sof));

  typedef struct {
    logic       rst;     // pulse reset before this vector
    logic       sel;     // 0 = check u_a, 1 = check u_b
    logic       mode;
    logic       sclr;
    logic       iv;
    logic [1:0] id;
    logic       ordy;
    logic       e_ir;    // in_ready before the edge
    logic       e_ov;    // outputs after the edge
    logic [1:0] e_od;
    logic       e_sof;
  } vec_t;

  vec_t tbl[$];

  // Binary symbol -> symbol-side label (Gray table when enabled).
  function automatic logic [1:0] gmap(input int s);
`ifdef DIFF_GRAY_EN
    case (s)
      0: return 2'd0;
      1: return 2'd1;
      2: return 2'd3;
      default: return 2'd2;
    endcase
`else
    return 2'(s);
`endif
  endfunction

  function automatic vec_t mk(input logic rst, sel, md, sc, iv, input logic [1:0] id,
                              input logic ordy, eir, eov, input logic [1:0] eod,
                              input logic esof);
    vec_t v;
    v.rst = rst; v.sel = sel; v.mode = md; v.sclr = sc; v.iv = iv; v.id = id;
    v.ordy = ordy; v.e_ir = eir; v.e_ov = eov; v.e_od = eod; v.e_sof = esof;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; in_valid = 1'b0; sync_clr = 1'b0; mode = 1'b0; out_ready = 1'b1;
    #2 rstn = 1'b1;
  endtask

  task automatic apply(input vec_t v, input string tag);
    if (v.rst) do_reset();
    @(negedge clk);
    mode = v.mode; sync_clr = v.sclr; in_valid = v.iv; in_data = v.id; out_ready = v.ordy;
    #1 chk({tag, ".in_ready"}, v.sel ? b_ir : a_ir, v.e_ir);
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, v.sel ? b_ov : a_ov, v.e_ov);
    chk({tag, ".out_data"},  v.sel ? b_od : a_od, v.e_od);
    chk({tag, ".out_sof"},   v.sel ? b_sof : a_sof, v.e_sof);
  endtask

  initial begin
    // Encode 01,11,10,01,00,10 -> 01,00,10,11,11,01
    tbl.push_back(mk(1,0,0,0,1,gmap(1),1, 1,1,2'd1,1));
    tbl.push_back(mk(0,0,0,0,1,gmap(3),1, 1,1,2'd0,0));
    tbl.push_back(mk(0,0,0,0,1,gmap(2),1, 1,1,2'd2,0));
    tbl.push_back(mk(0,0,0,0,1,gmap(1),1, 1,1,2'd3,0));
    tbl.push_back(mk(0,0,0,0,1,gmap(0),1, 1,1,2'd3,0));
    tbl.push_back(mk(0,0,0,0,1,gmap(2),1, 1,1,2'd1,0));
    // idle drains the output register; data holds
    tbl.push_back(mk(0,0,0,0,0,2'd0,1, 1,0,2'd1,0));
    // Decode (mode change forces a frame start): 01,00,10,11,11,01 -> 01,11,10,01,00,10
    tbl.push_back(mk(0,0,1,0,1,2'd1,1, 1,1,gmap(1),1));
    tbl.push_back(mk(0,0,1,0,1,2'd0,1, 1,1,gmap(3),0));
    tbl.push_back(mk(0,0,1,0,1,2'd2,1, 1,1,gmap(2),0));
    tbl.push_back(mk(0,0,1,0,1,2'd3,1, 1,1,gmap(1),0));
    tbl.push_back(mk(0,0,1,0,1,2'd3,1, 1,1,gmap(0),0));
    tbl.push_back(mk(0,0,1,0,1,2'd1,1, 1,1,gmap(2),0));
    // Frame wrap on FRAME_LEN=4: five 01 -> 01,10,11,00,01, sof on 1st and 5th
    tbl.push_back(mk(1,1,0,0,1,gmap(1),1, 1,1,2'd1,1));
    tbl.push_back(mk(0,1,0,0,1,gmap(1),1, 1,1,2'd2,0));
    tbl.push_back(mk(0,1,0,0,1,gmap(1),1, 1,1,2'd3,0));
    tbl.push_back(mk(0,1,0,0,1,gmap(1),1, 1,1,2'd0,0));
    tbl.push_back(mk(0,1,0,0,1,gmap(1),1, 1,1,2'd1,1));

    // Reset values
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rst.a_out_valid", a_ov, 0);
    chk("rst.a_out_data", a_od, 0);
    chk("rst.a_out_sof", a_sof, 0);
    chk("rst.a_in_ready", a_ir, 1);
    chk("rst.b_out_valid", b_ov, 0);
    #1 rstn = 1'b1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: one symbol out, then 3 stalled cycles, then release
    apply(mk(1,0,0,0,1,gmap(1),1, 1,1,2'd1,1), "bp0");
    for (int k = 0; k < 3; k++)
      apply(mk(0,0,0,0,1,gmap(1),0, 0,1,2'd1,1), $sformatf("bp_stall%0d", k));
    apply(mk(0,0,0,0,1,gmap(1),1, 1,1,2'd2,0), "bp_rel1");
    apply(mk(0,0,0,0,1,gmap(2),1, 1,1,2'd0,0), "bp_rel2");
    apply(mk(0,0,0,0,0,2'd0,1, 1,0,2'd0,0), "bp_drain");

    // Frame restart coincident with a transfer: 0+3 = 11, then continue from 11
    apply(mk(1,0,0,0,1,gmap(1),1, 1,1,2'd1,1), "sc0");
    apply(mk(0,0,0,1,1,gmap(3),1, 1,1,2'd3,1), "sc_hit");
    apply(mk(0,0,0,0,1,gmap(2),1, 1,1,2'd1,0), "sc2");
    apply(mk(0,0,0,0,1,gmap(1),1, 1,1,2'd2,0), "sc3");
    // Restart without a transfer: next symbol uses reference 0
    apply(mk(0,0,0,1,0,2'd0,1, 1,0,2'd2,0), "sc_idle");
    apply(mk(0,0,0,0,1,gmap(1),1, 1,1,2'd1,1), "sc_after");

    // Gray mapping (labels 11,10 when enabled) then async reset mid-stream
    apply(mk(1,0,0,0,1,gmap(2),1, 1,1,2'd2,1), "gr0");
    apply(mk(0,0,0,0,1,gmap(3),1, 1,1,2'd1,0), "gr1");
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1 chk("ar.held_valid", a_ov, 1);
    rstn = 1'b0;
    #1;
    chk("ar.out_valid", a_ov, 0);
    chk("ar.out_data", a_od, 0);
    chk("ar.in_ready", a_ir, 1);
    #1 rstn = 1'b1;
    apply(mk(0,0,0,0,1,gmap(2),1, 1,1,2'd2,1), "ar_next");
    apply(mk(0,0,0,0,0,2'd0,1, 1,0,2'd2,1), "ar_drain");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
